uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_arb_pkg.sv | 27 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 52 +++++
 rtl/uart_tx_arbiter.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// ---------------------------------------------------------------------------
// uart_arb_pkg
// Shared types and defaults for the UART transmit arbiter.
//   arb_state_t        : arbiter FSM states
//   DEF_N_REQ          : default number of requesters
//   DEF_TX_SIZE        : default frame width in bits
//   DEF_TIMEOUT_CYCLES : default watchdog limit (used with ARB_TIMEOUT_EN)
//   id_width()         : width of a requester index, never below 1 bit
// ---------------------------------------------------------------------------
package uart_arb_pkg;

    localparam int DEF_N_REQ          = 3;
    localparam int DEF_TX_SIZE        = 16;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority encoder. Searches req starting at
// (last + 1) mod N_REQ and returns the first asserted requester.
//   req   : request vector, one bit per requester
//   last  : index of the previously granted requester
//   valid : at least one request is asserted
//   index : winning requester (equals last when valid is low)
// ---------------------------------------------------------------------------
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int IDW   = id_width(DEF_N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   last,
    output logic             valid,
    output logic [IDW-1:0]   index
);

    // Candidate gi is the requester visited at search step gi. The sum
    // last+1+gi never reaches 2*N_REQ, so one conditional subtract is a
    // full modulo and one spare bit holds the sum.
    logic [IDW:0]   sum  [N_REQ];
    logic [IDW-1:0] cand [N_REQ];
    logic [N_REQ-1:0] hit;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_cand
            assign sum[gi]  = {1'b0, last} + (IDW+1)'(gi + 1);
            assign cand[gi] = (sum[gi] >= (IDW+1)'(N_REQ))
                            ? IDW'(sum[gi] - (IDW+1)'(N_REQ))
                            : IDW'(sum[gi]);
            assign hit[gi]  = req[cand[gi]];
        end
    endgenerate

    // Walk from the last step back to step 0 so the earliest step wins.
    always_comb begin
        valid = 1'b0;
        index = last;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (hit[i]) begin
                valid = 1'b1;
                index = cand[i];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter between N_REQ requesters with round-robin
// fairness. A grant latches the winner's frame, pulses its req_ready, then
// launches the transmitter and follows tx_busy through one full frame.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   When defined, a watchdog aborts a launch the transmitter never picks up
//   within TIMEOUT_CYCLES cycles and raises the sticky tx_timeout flag.
//
// Ports
//   CLOCK      in   system clock, rising edge
//   RESET_N    in   asynchronous active-low reset
//   req_valid  in   [N_REQ]          requester i has a frame pending
//   req_data   in   [N_REQ*TX_SIZE]  frame i at [i*TX_SIZE +: TX_SIZE]
//   req_ready  out  [N_REQ]          one-cycle accept pulse to the winner
//   tx_data    out  [TX_SIZE]        frame held for the transmitter
//   tx_start   out                   one-cycle launch pulse
//   tx_busy    in                    transmitter is shifting a frame
//   grant_id   out  [clog2(N_REQ)]   last granted requester
//   arb_busy   out                   high whenever the FSM is not IDLE
//   tx_timeout out                   sticky watchdog flag (ARB_TIMEOUT_EN)
// ---------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ          = DEF_N_REQ,
    parameter int TX_SIZE        = DEF_TX_SIZE,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                         CLOCK,
    input  logic                         RESET_N,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ*TX_SIZE-1:0]     req_data,
    output logic [N_REQ-1:0]             req_ready,
    output logic [TX_SIZE-1:0]           tx_data,
    output logic                         tx_start,
    input  logic                         tx_busy,
    output logic [id_width(N_REQ)-1:0]   grant_id,
`ifdef ARB_TIMEOUT_EN
    output logic                         tx_timeout,
`endif
    output logic                         arb_busy
);

    localparam int IDW = id_width(N_REQ);

    arb_state_t           state_reg;
    logic [N_REQ-1:0]     req_ready_reg;
    logic [TX_SIZE-1:0]   tx_data_reg;
    logic                 tx_start_reg;
    logic [IDW-1:0]       grant_reg;
    logic                 arb_busy_reg;

    logic                 pick_valid;
    logic [IDW-1:0]       pick_idx;
    logic [TX_SIZE-1:0]   frame [N_REQ];

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0]        wd_cnt_reg;
    logic                 timeout_reg;
`endif

    // Unpack the flat frame bus so the winner's frame is a simple array mux.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_frame
            assign frame[gi] = req_data[gi*TX_SIZE +: TX_SIZE];
        end
    endgenerate

    rr_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_rr_pick (
        .req   (req_valid),
        .last  (grant_reg),
        .valid (pick_valid),
        .index (pick_idx)
    );

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg     <= IDLE;
            req_ready_reg <= '0;
            tx_data_reg   <= '0;
            tx_start_reg  <= 1'b0;
            // Pointing at the last requester makes requester 0 win first.
            grant_reg     <= IDW'(N_REQ - 1);
            arb_busy_reg  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            wd_cnt_reg    <= '0;
            timeout_reg   <= 1'b0;
`endif
        end else begin
            // Both pulses default low; the states below raise them for
            // exactly one cycle.
            req_ready_reg <= '0;
            tx_start_reg  <= 1'b0;

            case (state_reg)
                IDLE: begin
                    // A transmitter that is already busy (driven by someone
                    // else) blocks any grant.
                    if (!tx_busy && pick_valid) begin
                        tx_data_reg   <= frame[pick_idx];
                        grant_reg     <= pick_idx;
                        req_ready_reg <= N_REQ'(1) << pick_idx;
                        state_reg     <= LAUNCH;
                        arb_busy_reg  <= 1'b1;
                    end
                end

                LAUNCH: begin
                    tx_start_reg <= 1'b1;
                    state_reg    <= WAIT_BUSY;
`ifdef ARB_TIMEOUT_EN
                    wd_cnt_reg   <= '0;
`endif
                end

                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state_reg <= WAIT_DONE;
`ifdef ARB_TIMEOUT_EN
                    end else if (wd_cnt_reg == CW'(TIMEOUT_CYCLES - 1)) begin
                        // Transmitter never took the frame: drop it.
                        timeout_reg  <= 1'b1;
                        state_reg    <= IDLE;
                        arb_busy_reg <= 1'b0;
                    end else begin
                        wd_cnt_reg <= wd_cnt_reg + 1'b1;
`endif
                    end
                end

                WAIT_DONE: begin
                    if (!tx_busy) begin
                        state_reg    <= IDLE;
                        arb_busy_reg <= 1'b0;
                    end
                end

                default: begin
                    state_reg    <= IDLE;
                    arb_busy_reg <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_reg;
    assign tx_data   = tx_data_reg;
    assign tx_start  = tx_start_reg;
    assign grant_id  = grant_reg;
    assign arb_busy  = arb_busy_reg;
`ifdef ARB_TIMEOUT_EN
    assign tx_timeout = timeout_reg;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter (3 requesters, 16-bit frames). Expected
// grants are queued when requests are driven and popped by a monitor when
// req_ready appears. A transmitter model raises busy two cycles after
// tx_start and holds it for 160 cycles. Build with +define+ARB_TIMEOUT_EN to
// add the watchdog scenario.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

`ifdef ARB_TIMEOUT_EN
    localparam int TO_CYC = 20;
`else
    localparam int TO_CYC = 255;
`endif

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] data;
    } exp_t;

    logic        clk;
    logic        RESET_N;
    logic [2:0]  req_valid;
    logic [47:0] req_data;
    logic [2:0]  req_ready;
    logic [15:0] tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic [1:0]  grant_id;
    logic        arb_busy;
`ifdef ARB_TIMEOUT_EN
    logic        tx_timeout;
`endif

    logic        model_busy;
    logic        model_en;
    logic        busy_force;
    assign tx_busy = model_busy | busy_force;

    int          checks = 0;
    int          errors = 0;
    int          readies = 0;
    int          starts = 0;
    int          pushes = 0;
    logic        prev_ready;
    logic [15:0] cur_data;
    exp_t        q[$];
    exp_t        e;

    uart_tx_arbiter #(
        .N_REQ          (3),
        .TX_SIZE        (16),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .CLOCK      (clk),
        .RESET_N    (RESET_N),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .grant_id   (grant_id),
`ifdef ARB_TIMEOUT_EN
        .tx_timeout (tx_timeout),
`endif
        .arb_busy   (arb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] id, input logic [15:0] data);
        exp_t x;
        x.id   = id;
        x.data = data;
        q.push_back(x);
        pushes++;
    endtask

    // Transmitter model: busy rises two cycles after tx_start, lasts 160.
    initial begin
        int pend;
        int bcnt;
        model_busy = 1'b0;
        pend = 0;
        bcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (tx_start && model_en) begin
                pend = 2;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    model_busy = 1'b1;
                    bcnt = 160;
                end
            end else if (model_busy) begin
                bcnt--;
                if (bcnt == 0) model_busy = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on every grant, checks launch timing.
    always @(negedge clk) begin
        if (!RESET_N) begin
            prev_ready = 1'b0;
        end else begin
            if (tx_start) begin
                starts++;
                check("start_after_ready", prev_ready, 1);
                check("start_data", tx_data, cur_data);
            end
            if (req_ready != 3'b000) begin
                check("ready_onehot", $countones(req_ready), 1);
                check("sb_nonempty", q.size() > 0, 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check("grant_id", grant_id, e.id);
                    check("grant_data", tx_data, e.data);
                    check("grant_ready", req_ready, 3'b001 << e.id);
                    cur_data = e.data;
                    $display("grant id=%0d data=%h ready=%b", grant_id, tx_data, req_ready);
                end
                readies++;
                prev_ready = 1'b1;
            end else begin
                prev_ready = 1'b0;
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_tx_start"}, tx_start, 0);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_tx_data"}, tx_data, 0);
        check({tag, "_arb_busy"}, arb_busy, 0);
        check({tag, "_grant_id"}, grant_id, 2);
`ifdef ARB_TIMEOUT_EN
        check({tag, "_tx_timeout"}, tx_timeout, 0);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        RESET_N = 1'b0;
        #3;
        check_reset_vals("rst");
        repeat (2) @(negedge clk);
        RESET_N = 1'b1;
    endtask

    task automatic wait_readies(input int target, input int budget, input string tag);
        int n = 0;
        while (readies < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(tag, readies >= target, 1);
    endtask

    // Follows one transmitter frame, then expects the arbiter back in IDLE.
    task automatic wait_frame_done(input string tag);
        int n = 0;
        while (!tx_busy && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({tag, "_busy_seen"}, tx_busy, 1);
        n = 0;
        while (tx_busy && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({tag, "_busy_fell"}, tx_busy, 0);
        @(negedge clk);
        check({tag, "_arb_idle"}, arb_busy, 0);
        check({tag, "_data_held"}, tx_data, cur_data);
    endtask

    initial begin
        int base;
        RESET_N    = 1'b0;
        req_valid  = 3'b000;
        req_data   = '0;
        model_en   = 1'b1;
        busy_force = 1'b0;
        prev_ready = 1'b0;
        cur_data   = '0;
        repeat (3) @(negedge clk);
        #3;
        check_reset_vals("por");
        RESET_N = 1'b1;

        // Single requester, frame dropped from the input after the grant.
        @(negedge clk); #1;
        req_data[15:0] = 16'hA55A;
        req_valid = 3'b001;
        push(0, 16'hA55A);
        wait_readies(1, 50, "t1_grant");
        req_valid = 3'b000;
        req_data  = '0;
        wait_frame_done("t1");
        check("t1_one_ready", readies, 1);

        // All requesters valid: rotation 0,1,2,0,1,2.
        do_reset();
        @(negedge clk); #1;
        req_data  = {16'h3333, 16'h2222, 16'h1111};
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) push(2'(k % 3), 16'h1111 * 16'(k % 3 + 1));
        wait_readies(7, 1500, "t2_grants");
        req_valid = 3'b000;
        wait_frame_done("t2");

        // Requesters 1 and 2 with last grant 1: expect 2 then 1.
        @(negedge clk); #1;
        req_valid = 3'b010;
        push(1, 16'h2222);
        wait_readies(8, 50, "t3_first");
        req_valid = 3'b110;
        push(2, 16'h3333);
        push(1, 16'h2222);
        wait_readies(10, 600, "t3_grants");
        req_valid = 3'b000;
        wait_frame_done("t3");

        // Reset pulse of 210 ns while the transmitter is mid-frame.
        @(negedge clk); #1;
        req_data  = {16'h3333, 16'h2222, 16'h0F0F};
        req_valid = 3'b001;
        push(0, 16'h0F0F);
        wait_readies(11, 50, "t4_grant");
        req_valid = 3'b000;
        base = 0;
        while (!tx_busy && base < 50) begin
            @(negedge clk); #1;
            base++;
        end
        check("t4_busy_seen", tx_busy, 1);
        repeat (3) @(negedge clk);
        #2;
        check("t4_in_wait_done", arb_busy, 1);
        RESET_N = 1'b0;
        #5;
        check_reset_vals("t4_early");
        #100;
        check_reset_vals("t4_late");
        #105;
        RESET_N = 1'b1;
        base = starts;
        repeat (200) @(negedge clk);
        check("t4_no_start", starts, base);
        check("t4_idle", arb_busy, 0);

        // Transmitter busy from elsewhere blocks the grant until it drops.
        @(negedge clk); #1;
        busy_force = 1'b1;
        req_data[15:0] = 16'hBEEF;
        req_valid = 3'b001;
        base = readies;
        repeat (10) @(negedge clk);
        check("t5_no_grant", readies, base);
        check("t5_idle", arb_busy, 0);
        #1;
        busy_force = 1'b0;
        push(0, 16'hBEEF);
        @(negedge clk);
        #1;
        check("t5_grant_next_edge", req_ready, 3'b001);
        req_valid = 3'b000;
        wait_frame_done("t5");

`ifdef ARB_TIMEOUT_EN
        // Transmitter never answers: watchdog drops the frame after 20 cycles.
        @(negedge clk); #1;
        model_en  = 1'b0;
        req_data  = {16'h3333, 16'h2222, 16'h4444};
        req_valid = 3'b011;
        push(1, 16'h2222);
        push(0, 16'h4444);
        base = 0;
        while (!tx_start && base < 50) begin
            @(negedge clk);
            base++;
        end
        check("t6_start_seen", tx_start, 1);
        req_valid = 3'b001;
        repeat (19) @(negedge clk);
        check("t6_no_timeout_yet", tx_timeout, 0);
        @(negedge clk);
        check("t6_timeout", tx_timeout, 1);
        check("t6_idle", arb_busy, 0);
        #1;
        model_en = 1'b1;
        @(negedge clk);
        #1;
        check("t6_next_grant", req_ready, 3'b001);
        req_valid = 3'b000;
        wait_frame_done("t6");
        check("t6_sticky", tx_timeout, 1);
`endif

        check("total_grants", readies, pushes);
        check("total_starts", starts, readies);
        check("sb_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Overall time bound in case a wait above misbehaves.
    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end

endmodule
